// File: rtl/gen_select_fifo_pkg.sv
// gen_select_fifo_pkg: shared constants and helpers for the select-path FIFO.
// Holds the read-path mode encodings and the pointer-width helper used by
// both the top level and the storage sub-module.
package gen_select_fifo_pkg;

   // Read-path selection values for the USE_FAST parameter.
   localparam int MODE_FAST = 1;
   localparam int MODE_SLOW = 0;

   // Pointer width for a given depth; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/gen_select_fifo_mem.sv
// gsf_mem: DEPTH x WIDTH storage array for gen_select_fifo.
// Synchronous write, asynchronous (combinational) read. The array itself is
// never reset; the FIFO pointers define which entries are meaningful.
module gsf_mem
   import gen_select_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry on an accepted push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/gen_select_fifo.sv
// gen_select_fifo: single-clock FIFO with a generate-selected read path.
//   USE_FAST = MODE_FAST : show-ahead, dout shows the head entry while non-empty.
//   USE_FAST = MODE_SLOW : registered, dout loads the head one cycle after a pop.
// Optional feature: define GEN_SELECT_FIFO_ERR_EN to add a sticky 'err' output
// that records any rejected push or ignored pop until the next reset.
module gen_select_fifo
   import gen_select_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int USE_FAST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
`ifdef GEN_SELECT_FIFO_ERR_EN
   ,
   output logic                     err
`endif
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_acc;
   logic          pop_acc;
   logic          mem_we;
   logic [CW-1:0] count_next;

   // Handshake acceptance and next occupancy. A pop on empty is ignored, so
   // push+pop while empty degenerates to a plain push. A push while full is
   // only allowed when a pop frees the slot in the same cycle.
   always_comb begin
      pop_acc    = pop && !empty;
      push_acc   = push && (!full || pop_acc);
      count_next = count;
      if (push_acc && !pop_acc) begin
         count_next = count + CW'(1);
      end else if (pop_acc && !push_acc) begin
         count_next = count - CW'(1);
      end
   end

   // Reset has priority, so nothing is written to storage during rst.
   assign mem_we = push_acc && !rst;

   // Pointer and occupancy state; full/empty are registered from the next count
   // so they stay consistent with count rather than with pointer equality.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         full  <= (count_next == DEPTH_C);
         empty <= (count_next == '0);
      end
   end

`ifdef GEN_SELECT_FIFO_ERR_EN
   // Sticky protocol-error flag: any rejected push or ignored pop sets it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if ((push && !push_acc) || (pop && !pop_acc)) begin
         err <= 1'b1;
      end
   end
`endif

   generate
      if (USE_FAST == MODE_FAST) begin : fast_rd
         logic [WIDTH-1:0] head;

         gsf_mem #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
         ) u_mem (
            .clk   (clk),
            .we    (mem_we),
            .waddr (wr_ptr),
            .wdata (din),
            .raddr (rd_ptr),
            .rdata (head)
         );

         // Show-ahead: the head entry is on dout whenever the FIFO holds data,
         // and a pop consumes exactly the word being displayed.
         always_comb begin
            dout     = empty ? '0 : head;
            rd_valid = !empty;
         end
      end else begin : slow_rd
         logic [WIDTH-1:0] head;
         logic [WIDTH-1:0] dout_p1;
         logic             vld_p1;

         gsf_mem #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
         ) u_mem (
            .clk   (clk),
            .we    (mem_we),
            .waddr (wr_ptr),
            .wdata (din),
            .raddr (rd_ptr),
            .rdata (head)
         );

         // Registered read: capture the head on an accepted pop; valid pulses
         // for one cycle and dout holds its last value in between. Reset clears
         // both so a pop pending at reset time is discarded.
         always_ff @(posedge clk) begin
            if (rst) begin
               dout_p1 <= '0;
               vld_p1  <= 1'b0;
            end else begin
               vld_p1 <= pop_acc;
               if (pop_acc) begin
                  dout_p1 <= head;
               end
            end
         end

         assign dout     = dout_p1;
         assign rd_valid = vld_p1;
      end
   endgenerate

endmodule

// File: doc/gen_select_fifo.md
GEN_SELECT_FIFO -- requirements
Module: gen_select_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entries; power of two, >=2.
REQ-003 SHALL have parameter USE_FAST, default 1; 1 = show-ahead read path, 0 = registered read path; selected by generate if/else.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port push  input  1  write request.
REQ-007 SHALL have port din  input  WIDTH  write data.
REQ-008 SHALL have port pop  input  1  read request.
REQ-009 SHALL have port dout  output  WIDTH  read data.
REQ-010 SHALL have port rd_valid  output  1  dout holds valid data.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL accept push only when !full or pop is accepted in the same cycle; rejected push leaves state unchanged.
REQ-015 SHALL accept pop only when !empty; pop on empty ignored.
REQ-016 SHALL, for simultaneous accepted push and pop, keep count unchanged and advance both pointers.
REQ-017 SHALL, on push+pop while empty, accept push only (count becomes 1).
REQ-018 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from count, not pointer equality.
REQ-019 SHALL, USE_FAST=1: drive dout = head entry combinationally when !empty, else all zeros; rd_valid = !empty; pop consumes the displayed word (zero latency).
REQ-020 SHALL, USE_FAST=0: on accepted pop load dout register with head entry; rd_valid = 1 exactly the cycle after an accepted pop, else 0; dout holds last value otherwise (1-cycle latency).
REQ-021 SHALL update count, full, empty registered, visible the cycle after the accepted operation.
REQ-022 SHALL preserve FIFO order across wrap-around for any DEPTH.

Reset
REQ-023 SHALL on rst: count=0, empty=1, full=0, rd_valid=0, dout=0, pointers=0; storage array not reset.
REQ-024 SHALL give rst priority over push/pop in the same cycle; mid-operation reset discards all entries and any pending USE_FAST=0 read.

Configuration
REQ-025 SHALL, with macro GEN_SELECT_FIFO_ERR_EN defined, add port err  output  1: sticky, set the cycle after a rejected push or ignored pop, cleared only by rst.
REQ-026 SHALL, without GEN_SELECT_FIFO_ERR_EN, omit err port and its logic; all other behaviour identical.

Structure
REQ-027 SHALL place ptr-width helper function and USE_FAST mode constants (MODE_FAST=1, MODE_SLOW=0) in package gen_select_fifo_pkg.
REQ-028 SHALL implement storage in one sub-module gsf_mem (DEPTH x WIDTH array, sync write, async read); both generate branches instantiate it.
REQ-029 SHALL keep generate branches named fast_rd and slow_rd.

Verification
REQ-030 SHALL cover: WIDTH=8, DEPTH=4, USE_FAST=1; push 0x11,0x22,0x33,0x44 -> full=1, count=4; dout=0x11, rd_valid=1 before any pop.
REQ-031 SHALL cover: USE_FAST=0, push 0xA5 then pop -> rd_valid=1 and dout=0xA5 one cycle after pop, rd_valid=0 next cycle.
REQ-032 SHALL cover: full FIFO, push 0x55 with pop -> count stays 4, popped word 0x11, 0x55 read after 0x44.
REQ-033 SHALL cover: 10 push/pop pairs through DEPTH=4 -> output sequence equals input sequence across two wraps.
REQ-034 SHALL cover: ERR_EN defined; pop on empty -> err=1 next cycle, remains 1 after further valid traffic, 0 after rst.
REQ-035 SHALL cover: rst asserted with count=3 and push=1 -> count=0, empty=1, dout=0 next cycle.
